// File: rtl/vector_unpack_pkg.sv
// Shared vector-machine definitions: word geometry, unpack state encoding,
// and the lane-slice helper used wherever a packed word is split into lanes.
package vector_unpack_pkg;

    localparam int VEC_WIDTH = 24;
    localparam int VEC_LANE  = 8;

    // Widest packed word the slice helper can address.
    localparam int SLICE_MAX = 256;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } unpack_state_t;

    // Returns lane `idx` of `word` in the low `lane` bits; upper bits are zero-padded.
    function automatic logic [SLICE_MAX-1:0] lane_slice(
        input logic [SLICE_MAX-1:0] word,
        input int unsigned          idx,
        input int unsigned          lane
    );
        logic [SLICE_MAX-1:0] mask;
        mask = ~({SLICE_MAX{1'b1}} << lane);
        return (word >> (idx * lane)) & mask;
    endfunction

endpackage

// File: rtl/vector_unpack.sv
// Splits one packed vector word into LANES scalar elements, lane 0 first,
// over a valid/ready stream; a new word may load on the final handshake.
module vector_unpack
    import vector_unpack_pkg::*;
#(
    parameter int WIDTH = VEC_WIDTH,
    parameter int LANE  = VEC_LANE,
    parameter int LANES = WIDTH / LANE,
    parameter int IDXW  = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             load_drop,
    output logic [LANE-1:0]  elem_out,
    output logic             elem_valid,
    input  logic             elem_ready,
    output logic [IDXW-1:0]  elem_idx,
    output logic             elem_last
);

    localparam int              NSLOT    = 1 << IDXW;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LANES - 1);

    unpack_state_t    state_reg;
    logic [WIDTH-1:0] word_reg;

    // Lane table sized to the full index range so every index value is legal;
    // slots beyond LANES-1 read as zero and are never selected.
    logic [LANE-1:0] lane_tbl [NSLOT];

    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_lane
            logic [SLICE_MAX-1:0] slice;
            assign slice       = lane_slice(SLICE_MAX'(word_reg), gi, LANE);
            assign lane_tbl[gi] = slice[LANE-1:0];
        end
    endgenerate

    logic            fire;
    logic            final_fire;
    logic            load_ok;
    logic [IDXW-1:0] idx_next;

    assign fire       = elem_valid && elem_ready;
    assign final_fire = fire && elem_last;
    assign load_ok    = load && ((state_reg == IDLE) || final_fire);
    assign idx_next   = elem_idx + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            word_reg   <= '0;
            busy       <= 1'b0;
            load_drop  <= 1'b0;
            elem_out   <= '0;
            elem_valid <= 1'b0;
            elem_idx   <= '0;
            elem_last  <= 1'b0;
        end else begin
            load_drop <= load && !load_ok;
            if (load_ok) begin
                state_reg  <= SEND;
                word_reg   <= data_in;
                busy       <= 1'b1;
                elem_out   <= data_in[LANE-1:0];
                elem_valid <= 1'b1;
                elem_idx   <= '0;
                elem_last  <= (LANES == 1);
            end else if (final_fire) begin
                state_reg  <= IDLE;
                busy       <= 1'b0;
                elem_valid <= 1'b0;
                elem_last  <= 1'b0;
            end else if (fire) begin
                elem_idx  <= idx_next;
                elem_out  <= lane_tbl[idx_next];
                elem_last <= (idx_next == LAST_IDX);
            end
        end
    end

endmodule

// File: tb/tb_vector_unpack.sv
// Directed bench for vector_unpack: default 24-bit instance plus a 32-bit
// instance for the parameterised geometry.
module tb_vector_unpack;

    logic        clk = 1'b0;
    logic        reset;

    logic        load;
    logic [23:0] data_in;
    logic        busy, load_drop, elem_valid, elem_ready, elem_last;
    logic [7:0]  elem_out;
    logic [1:0]  elem_idx;

    logic        load32;
    logic [31:0] data_in32;
    logic        busy32, load_drop32, elem_valid32, elem_ready32, elem_last32;
    logic [7:0]  elem_out32;
    logic [1:0]  elem_idx32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vector_unpack u_dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .data_in    (data_in),
        .busy       (busy),
        .load_drop  (load_drop),
        .elem_out   (elem_out),
        .elem_valid (elem_valid),
        .elem_ready (elem_ready),
        .elem_idx   (elem_idx),
        .elem_last  (elem_last)
    );

    vector_unpack #(.WIDTH(32), .LANE(8)) u_dut32 (
        .clk        (clk),
        .reset      (reset),
        .load       (load32),
        .data_in    (data_in32),
        .busy       (busy32),
        .load_drop  (load_drop32),
        .elem_out   (elem_out32),
        .elem_valid (elem_valid32),
        .elem_ready (elem_ready32),
        .elem_idx   (elem_idx32),
        .elem_last  (elem_last32)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end else begin
            $display("ok   %s: got %h", tag, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_elem(input string tag, input logic [7:0] out, input int idx, input logic last);
        check({tag, ".valid"}, 32'(elem_valid), 32'd1);
        check({tag, ".out"},   32'(elem_out),   32'(out));
        check({tag, ".idx"},   32'(elem_idx),   32'(idx));
        check({tag, ".last"},  32'(elem_last),  32'(last));
        check({tag, ".busy"},  32'(busy),       32'd1);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".valid"}, 32'(elem_valid), 32'd0);
        check({tag, ".busy"},  32'(busy),       32'd0);
        check({tag, ".last"},  32'(elem_last),  32'd0);
    endtask

    task automatic expect_elem32(input string tag, input logic [7:0] out, input int idx, input logic last);
        check({tag, ".valid"}, 32'(elem_valid32), 32'd1);
        check({tag, ".out"},   32'(elem_out32),   32'(out));
        check({tag, ".idx"},   32'(elem_idx32),   32'(idx));
        check({tag, ".last"},  32'(elem_last32),  32'(last));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        load = 1'b0; data_in = '0; elem_ready = 1'b0;
        load32 = 1'b0; data_in32 = '0; elem_ready32 = 1'b0;
        #1;
        check("rst.busy",  32'(busy),       32'd0);
        check("rst.valid", 32'(elem_valid), 32'd0);
        check("rst.last",  32'(elem_last),  32'd0);
        check("rst.drop",  32'(load_drop),  32'd0);
        check("rst.out",   32'(elem_out),   32'd0);
        check("rst.idx",   32'(elem_idx),   32'd0);
        #1;
        reset = 1'b0;

        // Plain stream with elem_ready held high
        load = 1'b1; data_in = 24'hC01401; elem_ready = 1'b1;
        tick();
        load = 1'b0;
        expect_elem("t1.e0", 8'h01, 0, 1'b0);
        tick(); expect_elem("t1.e1", 8'h14, 1, 1'b0);
        tick(); expect_elem("t1.e2", 8'hC0, 2, 1'b1);
        tick(); expect_idle("t1.end");

        // Stall of three cycles on lane 1, then zero-bubble reload on final handshake
        load = 1'b1; data_in = 24'hC01401;
        tick();
        load = 1'b0;
        expect_elem("t2.e0", 8'h01, 0, 1'b0);
        tick();
        elem_ready = 1'b0;
        expect_elem("t2.e1", 8'h14, 1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_elem($sformatf("t2.stall%0d", i), 8'h14, 1, 1'b0);
        end
        elem_ready = 1'b1;
        tick();
        expect_elem("t2.e2", 8'hC0, 2, 1'b1);
        load = 1'b1; data_in = 24'hD01402;
        tick();
        load = 1'b0;
        expect_elem("t3.e0", 8'h02, 0, 1'b0);
        check("t3.drop", 32'(load_drop), 32'd0);
        tick(); expect_elem("t3.e1", 8'h14, 1, 1'b0);
        tick(); expect_elem("t3.e2", 8'hD0, 2, 1'b1);
        tick(); expect_idle("t3.end");

        // Load while mid-word is refused
        load = 1'b1; data_in = 24'hC01401;
        tick();
        expect_elem("t4.e0", 8'h01, 0, 1'b0);
        data_in = 24'hFFFFFF;
        tick();
        load = 1'b0;
        expect_elem("t4.e1", 8'h14, 1, 1'b0);
        check("t4.drop1", 32'(load_drop), 32'd1);
        tick();
        expect_elem("t4.e2", 8'hC0, 2, 1'b1);
        check("t4.drop0", 32'(load_drop), 32'd0);
        tick(); expect_idle("t4.end");

        // Asynchronous reset mid-word
        load = 1'b1; data_in = 24'hC01401;
        tick();
        load = 1'b0;
        expect_elem("t5.e0", 8'h01, 0, 1'b0);
        tick();
        expect_elem("t5.e1", 8'h14, 1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        expect_idle("t5.rst");
        check("t5.rst.idx", 32'(elem_idx), 32'd0);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_idle($sformatf("t5.after%0d", i));
        end

        // 32-bit geometry: four lanes
        load32 = 1'b1; data_in32 = 32'h04030201; elem_ready32 = 1'b1;
        tick();
        load32 = 1'b0;
        expect_elem32("t6.e0", 8'h01, 0, 1'b0);
        tick(); expect_elem32("t6.e1", 8'h02, 1, 1'b0);
        tick(); expect_elem32("t6.e2", 8'h03, 2, 1'b0);
        tick(); expect_elem32("t6.e3", 8'h04, 3, 1'b1);
        tick();
        check("t6.end.valid", 32'(elem_valid32), 32'd0);
        check("t6.end.busy",  32'(busy32),       32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_unpack.md
Name: vector_unpack

Overview:
- Reverse of the vector-machine accumulate path. It loads one packed vector word (LANES elements of LANE bits each) and emits the elements one at a time, lane 0 (LSBs) first.
- Output uses a valid/ready handshake toward downstream scalar units.
- Back-to-back loads are possible with no bubble between words.

Parameters:
- WIDTH, 24, packed vector word width in bits; must be an exact multiple of LANE.
- LANE, 8, element width in bits.
- LANES, WIDTH/LANE (derived, 3 by default), number of elements per word.
- IDXW, clog2(LANES) with a minimum of 1 (derived), width of the lane index.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  request to capture data_in.
- data_in  in  WIDTH  packed vector; lane k occupies bits [k*LANE +: LANE].
- busy  out  1  high while a word is held and not fully emitted.
- load_drop  out  1  one-cycle pulse when a load is refused.
- elem_out  out  LANE  current element.
- elem_valid  out  1  elem_out is valid.
- elem_ready  in  1  downstream accepts the element.
- elem_idx  out  IDXW  lane number of elem_out.
- elem_last  out  1  high when elem_idx == LANES-1 and elem_valid is high.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - busy, load_drop, elem_valid and elem_last go to 0.
  - elem_out, elem_idx and the internal word register go to 0.
  - State goes to IDLE.
- States: IDLE, SEND.
- IDLE:
  - load=1 captures data_in at the clock edge and moves to SEND.
  - Next cycle: elem_valid=1, elem_idx=0, elem_out = lane 0. Load-to-first-element latency is 1 cycle.
- SEND:
  - elem_out, elem_idx and elem_last stay stable while elem_valid=1 and elem_ready=0. A stall of any length must hold them.
  - elem_valid & elem_ready with elem_idx < LANES-1: elem_idx increments and the next lane appears the following cycle.
  - elem_valid & elem_ready with elem_last=1 and load=0: return to IDLE; elem_valid=0 and busy=0 next cycle.
  - elem_valid & elem_ready with elem_last=1 and load=1: capture the new word and stay in SEND. Next cycle shows lane 0 of the new word (zero-bubble).
- Load acceptance:
  - load is accepted only in IDLE or on the final-element handshake cycle.
  - load=1 at any other time is ignored: the held word is unchanged and load_drop pulses high for exactly the next cycle.
- busy equals (state == SEND); it is registered.
- elem_valid never asserts in IDLE.
- elem_ready is ignored when elem_valid=0.
- Reset asserted mid-word aborts the word: the remaining lanes are discarded and there is no partial output after reset releases.
- No arithmetic is performed. Lane extraction is a plain bit-slice with no sign handling.
- elem_idx wraps only via reload; it never exceeds LANES-1.

Decomposition:
- Shared vector-machine package holds:
  - VEC_WIDTH=24 and VEC_LANE=8 constants, shared with the accumulate block.
  - State encoding: IDLE=1'b0, SEND=1'b1.
  - The lane-slice helper function.
- No sub-module is needed. The FSM, lane counter and word register fit in one module; the lane mux is inline.

Test Plan:
- Reset 2 ns, then load=1 for one cycle with data_in=24'hC01401 and elem_ready=1 constant -> elem_out sequence 8'h01, 8'h14, 8'hC0 on consecutive cycles, elem_idx 0,1,2, elem_last only with 8'hC0, then busy=0.
- Same word with elem_ready=0 for 3 cycles at idx 1 -> elem_out holds 8'h14 and elem_idx holds 1 across the stall; resumes with 8'hC0.
- load=1 with 24'hD01402 on the cycle that 8'hC0 handshakes -> next cycle shows 8'h02 at idx 0 with no idle cycle; the sequence 02, 14, D0 follows.
- load=1 with 24'hFFFFFF while at idx 0 of 24'hC01401 -> load_drop pulses for one cycle; the output still completes 01, 14, C0.
- Assert reset mid-word at idx 1, asynchronously between edges -> elem_valid, busy and elem_idx drop to 0 immediately; after release, no output until a new load.
- Parameter check with WIDTH=32, LANE=8 and 32'h04030201 -> 01, 02, 03, 04, with elem_last on 04.
